// File: rtl/fp2_hadamard_if.sv
// Handshake and data bundle for the Fp2 Hadamard stage.
// master = upstream producer / downstream consumer side, slave = the transform block.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid must not depend on ready, data is only meaningful while valid is 1.
interface fp2_hadamard_if #(
    parameter int WIDTH = 255
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X1_re, X1_im, X2_re, X2_im, X3_re, X3_im, X4_re, X4_im;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] H1_re, H1_im, H2_re, H2_im, H3_re, H3_im, H4_re, H4_im;

    modport master (
        output in_valid, X1_re, X1_im, X2_re, X2_im, X3_re, X3_im, X4_re, X4_im,
        output out_ready,
        input  in_ready, out_valid,
        input  H1_re, H1_im, H2_re, H2_im, H3_re, H3_im, H4_re, H4_im
    );

    modport slave (
        input  in_valid, X1_re, X1_im, X2_re, X2_im, X3_re, X3_im, X4_re, X4_im,
        input  out_ready,
        output in_ready, out_valid,
        output H1_re, H1_im, H2_re, H2_im, H3_re, H3_im, H4_re, H4_im
    );
endinterface

// File: rtl/fp2_hadamard.sv
// Two-stage pipelined Hadamard transform over four Fp2 elements, p = 5*2^248 - 1.
// Stage 1 forms the butterflies (x1+-x2, x3+-x4), stage 2 combines them into h1..h4.
// Each stage carries a valid flag; a stage advances when it is empty or the stage
// after it advances, giving full backpressure with two vectors in flight.
module fp2_hadamard #(
    parameter int               WIDTH = 255,
    parameter logic [WIDTH-1:0] P     = (WIDTH'(5) << 248) - WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    fp2_hadamard_if.slave       bus
);

    // Reduced modular add: both operands are already in [0, P).
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        logic [WIDTH:0] t;
        s = {1'b0, a} + {1'b0, b};
        t = s - {1'b0, P};
        if (s >= {1'b0, P}) return t[WIDTH-1:0];
        return s[WIDTH-1:0];
    endfunction

    // Reduced modular subtract: the top bit of the widened difference is the borrow.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        logic [WIDTH:0] t;
        d = {1'b0, a} - {1'b0, b};
        t = d + {1'b0, P};
        if (d[WIDTH]) return t[WIDTH-1:0];
        return d[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] x_re [4];
    logic [WIDTH-1:0] x_im [4];

    // Stage 1 holds u1..u4 (index 0..3), stage 2 holds h1..h4 (index 0..3).
    logic [WIDTH-1:0] u_re_d [4];
    logic [WIDTH-1:0] u_re_q [4];
    logic [WIDTH-1:0] u_im_d [4];
    logic [WIDTH-1:0] u_im_q [4];
    logic [WIDTH-1:0] h_re_d [4];
    logic [WIDTH-1:0] h_re_q [4];
    logic [WIDTH-1:0] h_im_d [4];
    logic [WIDTH-1:0] h_im_q [4];
    logic             v1_d, v1_q;
    logic             v2_d, v2_q;
    logic             adv1, adv2;

    assign x_re[0] = bus.X1_re;
    assign x_re[1] = bus.X2_re;
    assign x_re[2] = bus.X3_re;
    assign x_re[3] = bus.X4_re;
    assign x_im[0] = bus.X1_im;
    assign x_im[1] = bus.X2_im;
    assign x_im[2] = bus.X3_im;
    assign x_im[3] = bus.X4_im;

    // Stall control and next-state for both stages; a stage that does not advance holds.
    always_comb begin
        adv2   = !v2_q || bus.out_ready;
        adv1   = !v1_q || adv2;
        v1_d   = v1_q;
        v2_d   = v2_q;
        u_re_d = u_re_q;
        u_im_d = u_im_q;
        h_re_d = h_re_q;
        h_im_d = h_im_q;
        if (adv1) begin
            v1_d      = bus.in_valid;
            u_re_d[0] = mod_add(x_re[0], x_re[1]);
            u_re_d[1] = mod_sub(x_re[0], x_re[1]);
            u_re_d[2] = mod_add(x_re[2], x_re[3]);
            u_re_d[3] = mod_sub(x_re[2], x_re[3]);
            u_im_d[0] = mod_add(x_im[0], x_im[1]);
            u_im_d[1] = mod_sub(x_im[0], x_im[1]);
            u_im_d[2] = mod_add(x_im[2], x_im[3]);
            u_im_d[3] = mod_sub(x_im[2], x_im[3]);
        end
        if (adv2) begin
            v2_d      = v1_q;
            h_re_d[0] = mod_add(u_re_q[0], u_re_q[2]);
            h_re_d[1] = mod_add(u_re_q[1], u_re_q[3]);
            h_re_d[2] = mod_sub(u_re_q[0], u_re_q[2]);
            h_re_d[3] = mod_sub(u_re_q[1], u_re_q[3]);
            h_im_d[0] = mod_add(u_im_q[0], u_im_q[2]);
            h_im_d[1] = mod_add(u_im_q[1], u_im_q[3]);
            h_im_d[2] = mod_sub(u_im_q[0], u_im_q[2]);
            h_im_d[3] = mod_sub(u_im_q[1], u_im_q[3]);
        end
    end

    // Pipeline registers; data is cleared on reset only to keep outputs X-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                u_re_q[i] <= '0;
                u_im_q[i] <= '0;
                h_re_q[i] <= '0;
                h_im_q[i] <= '0;
            end
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            u_re_q <= u_re_d;
            u_im_q <= u_im_d;
            h_re_q <= h_re_d;
            h_im_q <= h_im_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_q;
    assign bus.H1_re     = h_re_q[0];
    assign bus.H1_im     = h_im_q[0];
    assign bus.H2_re     = h_re_q[1];
    assign bus.H2_im     = h_im_q[1];
    assign bus.H3_re     = h_re_q[2];
    assign bus.H3_im     = h_im_q[2];
    assign bus.H4_re     = h_re_q[3];
    assign bus.H4_im     = h_im_q[3];

endmodule

// File: tb/tb_fp2_hadamard.sv
// Bench for fp2_hadamard: directed vectors, backpressure, mid-stream reset and a
// randomized burst, checked against a modular-arithmetic reference in a scoreboard.
module tb_fp2_hadamard;

    localparam int W  = 255;
    localparam int VW = 8 * W;
    localparam logic [W-1:0] P = 255'd5 * (255'd1 << 248) - 255'd1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] mon_obs, mon_exp, prev_h;
    logic          prev_stall;

    fp2_hadamard_if #(.WIDTH(W)) bus ();

    fp2_hadamard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    // Coordinate index = 2*lane + component (component 0 = re, 1 = im).
    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int idx,
                                          input logic [W-1:0] val);
        logic [VW-1:0] r;
        r = v;
        r[idx*W +: W] = val;
        return r;
    endfunction

    function automatic logic [W-1:0] get(input logic [VW-1:0] v, input int idx);
        return v[idx*W +: W];
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        logic [VW-1:0] r;
        r = '0;
        r = put(r, 0, bus.H1_re);
        r = put(r, 1, bus.H1_im);
        r = put(r, 2, bus.H2_re);
        r = put(r, 3, bus.H2_im);
        r = put(r, 4, bus.H3_re);
        r = put(r, 5, bus.H3_im);
        r = put(r, 6, bus.H4_re);
        r = put(r, 7, bus.H4_im);
        return r;
    endfunction

    // Reference: each output is the signed sum of the inputs reduced with %.
    function automatic logic [VW-1:0] model(input logic [VW-1:0] x);
        logic [259:0] a [4];
        logic [259:0] pp;
        logic [VW-1:0] r;
        pp = {5'b0, P};
        r  = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) a[k] = {5'b0, get(x, 2*k + c)};
            r = put(r, 0 + c, W'((a[0] + a[1] + a[2] + a[3]) % pp));
            r = put(r, 2 + c, W'((a[0] + a[2] + pp + pp - a[1] - a[3]) % pp));
            r = put(r, 4 + c, W'((a[0] + a[1] + pp + pp - a[2] - a[3]) % pp));
            r = put(r, 6 + c, W'((a[0] + a[3] + pp + pp - a[1] - a[2]) % pp));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_coord();
        logic [255:0] t;
        int           sel;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return 255'd1;
        if (sel == 2) return P - 255'd1;
        return t[W-1:0] % P;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = put(r, i, rand_coord());
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_x(input logic [VW-1:0] x);
        bus.X1_re = get(x, 0);
        bus.X1_im = get(x, 1);
        bus.X2_re = get(x, 2);
        bus.X2_im = get(x, 3);
        bus.X3_re = get(x, 4);
        bus.X3_im = get(x, 5);
        bus.X4_re = get(x, 6);
        bus.X4_im = get(x, 7);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [VW-1:0] x, input logic [VW-1:0] e, input bit rand_bp);
        bit accepted;
        int cnt;
        accepted = 1'b0;
        cnt      = 0;
        drive_x(x);
        bus.in_valid = 1'b1;
        while (!accepted && cnt < 64) begin
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            accepted = (bus.in_ready === 1'b1);
            if (accepted) exp_q.push_back(e);
            @(posedge clk);
            #1;
            cnt++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        assert (accepted) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed in_ready=0 for %0d cycles, required acceptance", cnt);
        end
    endtask

    // After an acceptance with out_ready=1: result is absent after the next edge's
    // preceding half-cycle and present after the following edge.
    task automatic check_latency();
        @(negedge clk);
        n_checks++;
        assert (bus.out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL latency_early: observed out_valid=%b, required 0", bus.out_valid);
        end
        @(negedge clk);
        n_checks++;
        assert (bus.out_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL latency_due: observed out_valid=%b, required 1", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_valid(input string tag, input logic req);
        @(negedge clk);
        n_checks++;
        assert (bus.out_valid === req) else begin
            n_fail++;
            $error("FAIL %s: observed out_valid=%b, required %b", tag, bus.out_valid, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            mon_obs = obs_vec();
            if (prev_stall) begin
                n_checks++;
                assert (bus.out_valid === 1'b1) else begin
                    n_fail++;
                    $error("FAIL stall_valid: observed out_valid=%b, required 1", bus.out_valid);
                end
                for (int i = 0; i < 8; i++) begin
                    n_checks++;
                    assert (get(mon_obs, i) === get(prev_h, i)) else begin
                        n_fail++;
                        $error("FAIL stall_hold_%0d: observed %h, required %h", i, get(mon_obs, i), get(prev_h, i));
                    end
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed result %h, required none", get(mon_obs, 0));
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        n_checks++;
                        assert (get(mon_obs, i) === get(mon_exp, i)) else begin
                            n_fail++;
                            $error("FAIL out_coord_%0d: observed %h, required %h", i, get(mon_obs, i), get(mon_exp, i));
                        end
                    end
                end
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            prev_h     = mon_obs;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [VW-1:0] x, e, va, vb, vc;
        n_checks      = 0;
        n_fail        = 0;
        prev_stall    = 1'b0;
        prev_h        = '0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_x('0);

        // Reset state
        repeat (3) @(negedge clk);
        n_checks++;
        assert (bus.out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_out_valid: observed %b, required 0", bus.out_valid);
        end
        n_checks++;
        assert (bus.in_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL reset_in_ready: observed %b, required 1", bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Identity: x1=(1,0) -> every h = (1,0)
        x = put('0, 0, 255'd1);
        e = put(put(put(put('0, 0, 255'd1), 2, 255'd1), 4, 255'd1), 6, 255'd1);
        send(x, e, 1'b0);
        check_latency();

        // All zero
        send('0, '0, 1'b0);
        check_latency();

        // Sign pattern: x2=(1,0)
        x = put('0, 2, 255'd1);
        e = put(put(put(put('0, 0, 255'd1), 2, P - 255'd1), 4, 255'd1), 6, P - 255'd1);
        send(x, e, 1'b0);
        check_latency();

        // Wrap: all coordinates P-1
        x = '0;
        for (int i = 0; i < 8; i++) x = put(x, i, P - 255'd1);
        e = put(put('0, 0, P - 255'd4), 1, P - 255'd4);
        send(x, e, 1'b0);
        check_latency();

        // Wrap: x1=(P-1,0), x2=(1,0)
        x = put(put('0, 0, P - 255'd1), 2, 255'd1);
        e = put(put('0, 2, P - 255'd2), 6, P - 255'd2);
        send(x, e, 1'b0);
        check_latency();

        // Streaming: two vectors back to back, results on consecutive cycles
        va = rand_vec();
        vb = rand_vec();
        send(va, model(va), 1'b0);
        send(vb, model(vb), 1'b0);
        check_out_valid("stream_first", 1'b1);
        check_out_valid("stream_second", 1'b1);
        check_out_valid("stream_idle", 1'b0);
        @(posedge clk);
        #1;

        // Backpressure: third vector refused while two are held
        bus.out_ready = 1'b0;
        va = rand_vec();
        vb = rand_vec();
        vc = rand_vec();
        send(va, model(va), 1'b0);
        send(vb, model(vb), 1'b0);
        drive_x(vc);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            assert (bus.in_ready === 1'b0) else begin
                n_fail++;
                $error("FAIL full_in_ready: observed %b, required 0", bus.in_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(vc, model(vc), 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL bp_drain: observed %0d pending, required 0", exp_q.size());
        end

        // Reset with two vectors in flight
        bus.out_ready = 1'b0;
        va = rand_vec();
        vb = rand_vec();
        send(va, model(va), 1'b0);
        send(vb, model(vb), 1'b0);
        rst = 1'b0;
        #1;
        n_checks++;
        assert (bus.out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL midrst_out_valid: observed %b, required 0", bus.out_valid);
        end
        n_checks++;
        assert (bus.in_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL midrst_in_ready: observed %b, required 1", bus.in_ready);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        assert (bus.in_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL post_rst_in_ready: observed %b, required 1", bus.in_ready);
        end
        va = rand_vec();
        send(va, model(va), 1'b0);
        check_latency();

        // Randomized burst with random backpressure
        for (int n = 0; n < 40; n++) begin
            va = rand_vec();
            send(va, model(va), 1'b1);
        end

        // Drain and watch for duplicates
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL final_drain: observed %0d pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
